tex_conv_pipe: RTL and testbench

TEX_CONV_PIPE -- requirements
Module: tex_conv_pipe

---
 rtl/tex_conv_pipe.sv | 174 +++++++++++++++++
 tb/tb_tex_conv_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_conv_pipe.sv
// Texture format converter: CLUT index generation, fixed-latency CLUT delay line and credit-managed output FIFO.
// Optional macro TEX_CONV_PIPE_BYPASS_EN lets an exiting beat skip an empty FIFO when the consumer is ready.
module tex_conv_pipe #(
  parameter int LANES     = 2,
  parameter int CLUT_LAT  = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic [1:0]            GPU_REG_TexFormat,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES-1:0]      i_laneMask,
  input  logic [16*LANES-1:0]   i_data,
  input  logic [2*LANES-1:0]    i_uLSB,
  output logic [LANES-1:0]      o_lookupValid,
  output logic [8*LANES-1:0]    o_indexLookup,
  input  logic [16*LANES-1:0]   i_clutValue,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANES-1:0]      o_laneMask,
  output logic [16*LANES-1:0]   o_pixel,
  output logic [LANES-1:0]      o_transparentBlack
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int EX = CLUT_LAT - 1;

  typedef enum logic [1:0] {
    FMT_4BPP  = 2'd0,
    FMT_8BPP  = 2'd1,
    FMT_16BPP = 2'd2,
    FMT_RSVD  = 2'd3
  } texFmt_t;

  logic                  accept;
  logic [CW-1:0]         fifoCount;
  logic [CW-1:0]         inflight;
  logic [SW-1:0]         credits;

  logic                  stValid [CLUT_LAT];
  logic                  stRaw   [CLUT_LAT];
  logic [LANES-1:0]      stMask  [CLUT_LAT];
  logic [16*LANES-1:0]   stData  [CLUT_LAT];

  logic                  exValid;
  logic [LANES-1:0]      exMask;
  logic [LANES-1:0]      exTb;
  logic [16*LANES-1:0]   exPixel;

  logic [LANES-1:0]      memMask  [OUT_DEPTH];
  logic [16*LANES-1:0]   memPixel [OUT_DEPTH];
  logic [LANES-1:0]      memTb    [OUT_DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic                  fifoEmpty;
  logic                  bypassTake;
  logic                  push;
  logic                  pop;

  // Credit covers both stored beats and beats still waiting on the CLUT.
  always_comb begin
    inflight = '0;
    for (int s = 0; s < CLUT_LAT; s++) inflight = inflight + CW'(stValid[s]);
  end

  assign credits = SW'(fifoCount) + SW'(inflight);
  assign o_ready = credits < SW'(OUT_DEPTH);
  assign accept  = i_valid & o_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_indexLookup = '0;
    o_lookupValid = '0;
    for (int n = 0; n < LANES; n++) begin
      case (texFmt_t'(GPU_REG_TexFormat))
        FMT_4BPP: o_indexLookup[8*n +: 8] = {4'd0, i_data[16*n + 4*i_uLSB[2*n +: 2] +: 4]};
        FMT_8BPP: o_indexLookup[8*n +: 8] = i_uLSB[2*n] ? i_data[16*n + 8 +: 8] : i_data[16*n +: 8];
        default:  o_indexLookup[8*n +: 8] = 8'd0;
      endcase
      o_lookupValid[n] = accept & i_laneMask[n] & ~GPU_REG_TexFormat[1];
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int s = 0; s < CLUT_LAT; s++) begin
        stValid[s] <= 1'b0;
        stRaw[s]   <= 1'b0;
        stMask[s]  <= '0;
        stData[s]  <= '0;
      end
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's value from before this edge.
      stValid[0] <= accept;
      stRaw[0]   <= GPU_REG_TexFormat[1];
      stMask[0]  <= i_laneMask;
      stData[0]  <= i_data;
      for (int s = 1; s < CLUT_LAT; s++) begin
        stValid[s] <= stValid[s-1];
        stRaw[s]   <= stRaw[s-1];
        stMask[s]  <= stMask[s-1];
        stData[s]  <= stData[s-1];
      end
    end
  end

  // The CLUT answer lines up with the last delay stage; 16bpp and reserved pass raw data.
  always_comb begin
    exValid = stValid[EX];
    exMask  = stMask[EX];
    exPixel = '0;
    exTb    = '0;
    for (int n = 0; n < LANES; n++) begin
      if (exMask[n]) begin
        exPixel[16*n +: 16] = stRaw[EX] ? stData[EX][16*n +: 16] : i_clutValue[16*n +: 16];
        exTb[n]             = (exPixel[16*n +: 15] == 15'd0);
      end
    end
  end

  assign fifoEmpty = (fifoCount == '0);
`ifdef TEX_CONV_PIPE_BYPASS_EN
  assign bypassTake = exValid & fifoEmpty & i_ready;
`else
  assign bypassTake = 1'b0;
`endif
  assign push = exValid & ~bypassTake;
  assign pop  = ~fifoEmpty & i_ready;

  // NOTE: storage is left unreset on purpose; fifoCount decides what can reach the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      memMask[wrPtr]  <= exMask;
      memPixel[wrPtr] <= exPixel;
      memTb[wrPtr]    <= exTb;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_comb begin
    o_valid            = ~fifoEmpty | bypassTake;
    o_laneMask         = '0;
    o_pixel            = '0;
    o_transparentBlack = '0;
    if (!fifoEmpty) begin
      o_laneMask         = memMask[rdPtr];
      o_pixel            = memPixel[rdPtr];
      o_transparentBlack = memTb[rdPtr];
    end else if (bypassTake) begin
      o_laneMask         = exMask;
      o_pixel            = exPixel;
      o_transparentBlack = exTb;
    end
  end

endmodule

// File: tb/tb_tex_conv_pipe.sv
// Directed bench for tex_conv_pipe: vector table for single beats plus fill, reset and format-change sequences.
module tb_tex_conv_pipe;

  localparam int LANES     = 2;
  localparam int CLUT_LAT  = 1;
  localparam int OUT_DEPTH = 4;
`ifdef TEX_CONV_PIPE_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic                 clk;
  logic                 i_nrst;
  logic [1:0]           GPU_REG_TexFormat;
  logic                 i_valid;
  logic                 o_ready;
  logic [LANES-1:0]     i_laneMask;
  logic [16*LANES-1:0]  i_data;
  logic [2*LANES-1:0]   i_uLSB;
  logic [LANES-1:0]     o_lookupValid;
  logic [8*LANES-1:0]   o_indexLookup;
  logic [16*LANES-1:0]  i_clutValue;
  logic                 o_valid;
  logic                 i_ready;
  logic [LANES-1:0]     o_laneMask;
  logic [16*LANES-1:0]  o_pixel;
  logic [LANES-1:0]     o_transparentBlack;

  tex_conv_pipe #(.LANES(LANES), .CLUT_LAT(CLUT_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .i_nrst(i_nrst), .GPU_REG_TexFormat(GPU_REG_TexFormat),
    .i_valid(i_valid), .o_ready(o_ready), .i_laneMask(i_laneMask),
    .i_data(i_data), .i_uLSB(i_uLSB), .o_lookupValid(o_lookupValid),
    .o_indexLookup(o_indexLookup), .i_clutValue(i_clutValue),
    .o_valid(o_valid), .i_ready(i_ready), .o_laneMask(o_laneMask),
    .o_pixel(o_pixel), .o_transparentBlack(o_transparentBlack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CLUT model: one-cycle registered lookup; lanes without a request return a poison value.
  function automatic logic [15:0] clutFn(input logic [7:0] idx);
    case (idx)
      8'hAB:   return 16'h7C00;
      8'h04:   return 16'h8000;
      8'h01:   return 16'h1234;
      8'h00:   return 16'h0000;
      default: return {~idx, idx};
    endcase
  endfunction

  logic [16*LANES-1:0] clutQ;
  always @(posedge clk) begin
    for (int n = 0; n < LANES; n++)
      clutQ[16*n +: 16] <= o_lookupValid[n] ? clutFn(o_indexLookup[8*n +: 8]) : 16'hDEAD;
  end
  assign i_clutValue = clutQ;

  typedef struct {
    logic [1:0]  fmt;
    logic [1:0]  mask;
    logic [31:0] data;
    logic [3:0]  uLsb;
    logic [1:0]  expLookup;
    logic [15:0] expIdx;
    logic [1:0]  expMask;
    logic [31:0] expPix;
    logic [1:0]  expTb;
  } vec_t;

  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyVec(input int i, input vec_t v);
    logic [15:0] idxMask;
    int lat;
    @(negedge clk);
    GPU_REG_TexFormat = v.fmt;
    i_laneMask        = v.mask;
    i_data            = v.data;
    i_uLSB            = v.uLsb;
    i_valid           = 1'b1;
    i_ready           = 1'b1;
    #1;
    idxMask = {{8{v.expLookup[1]}}, {8{v.expLookup[0]}}};
    check($sformatf("v%0d ready", i), o_ready, 1);
    check($sformatf("v%0d lookupValid", i), o_lookupValid, v.expLookup);
    check($sformatf("v%0d index", i), o_indexLookup & idxMask, v.expIdx & idxMask);
    @(posedge clk);
    @(negedge clk);
    i_valid           = 1'b0;
    i_data            = 32'hFFFF_FFFF;
    GPU_REG_TexFormat = 2'd0;
    #1;
    lat = 0;
    while (!o_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d latency", i), lat, EXP_LAT);
    check($sformatf("v%0d laneMask", i), o_laneMask, v.expMask);
    check($sformatf("v%0d pixel", i), o_pixel, v.expPix);
    check($sformatf("v%0d transparentBlack", i), o_transparentBlack, v.expTb);
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d drained", i), o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] expSeq[3];
    int accepted;
    logic accNow;

    vecs[0] = '{2'd1, 2'b01, 32'h0000_AB12, 4'b0001, 2'b01, 16'h00AB, 2'b01, 32'h0000_7C00, 2'b00};
    vecs[1] = '{2'd0, 2'b11, 32'h4321_4321, 4'b0011, 2'b11, 16'h0104, 2'b11, 32'h1234_8000, 2'b01};
    vecs[2] = '{2'd2, 2'b11, 32'h0000_0000, 4'b0000, 2'b00, 16'h0000, 2'b11, 32'h0000_0000, 2'b11};
    vecs[3] = '{2'd3, 2'b11, 32'h0000_0000, 4'b0000, 2'b00, 16'h0000, 2'b11, 32'h0000_0000, 2'b11};
    vecs[4] = '{2'd2, 2'b11, 32'h8000_1234, 4'b0000, 2'b00, 16'h0000, 2'b11, 32'h8000_1234, 2'b10};
    vecs[5] = '{2'd1, 2'b10, 32'h55AA_FFFF, 4'b1011, 2'b10, 16'hAA00, 2'b10, 32'h55AA_0000, 2'b00};
    vecs[6] = '{2'd0, 2'b11, 32'h00C0_BEEF, 4'b1001, 2'b11, 16'h000E, 2'b11, 32'h0000_F10E, 2'b10};
    vecs[7] = '{2'd1, 2'b00, 32'h1111_2222, 4'b0000, 2'b00, 16'h0000, 2'b00, 32'h0000_0000, 2'b00};
    vecs[8] = '{2'd1, 2'b11, 32'h3C5A_9F01, 4'b0100, 2'b11, 16'h3C01, 2'b11, 32'hC33C_1234, 2'b00};

    i_nrst = 1'b1; GPU_REG_TexFormat = 2'd0; i_valid = 1'b0; i_ready = 1'b0;
    i_laneMask = '0; i_data = '0; i_uLSB = '0;
    #1 i_nrst = 1'b0;
    #1;
    check("reset o_valid", o_valid, 0);
    check("reset o_pixel", o_pixel, 0);
    check("reset o_laneMask", o_laneMask, 0);
    check("reset o_transparentBlack", o_transparentBlack, 0);
    repeat (3) @(negedge clk);
    i_nrst = 1'b1;
    #1 check("ready after reset", o_ready, 1);

    foreach (vecs[i]) applyVec(i, vecs[i]);

    // Fill with the consumer stalled: credit must stop acceptance at OUT_DEPTH beats.
    @(negedge clk);
    i_ready = 1'b0; GPU_REG_TexFormat = 2'd2; i_laneMask = 2'b11; i_uLSB = '0;
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      i_data  = {16'(16'h2000 + accepted), 16'(16'h1000 + accepted)};
      i_valid = 1'b1;
      #1 accNow = o_ready;
      @(posedge clk);
      if (accNow) accepted++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    #1;
    check("fill accepted", accepted, OUT_DEPTH);
    check("fill o_ready", o_ready, 0);
    check("fill o_valid", o_valid, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 check($sformatf("stall hold %0d", c), o_pixel, 32'h2000_1000);
    end
    i_ready = 1'b1;
    #1 check("no credit before pop", o_ready, 0);
    for (int k = 0; k < OUT_DEPTH; k++) begin
      check($sformatf("drain %0d valid", k), o_valid, 1);
      check($sformatf("drain %0d pixel", k), o_pixel, {16'(16'h2000 + k), 16'(16'h1000 + k)});
      check($sformatf("drain %0d mask", k), o_laneMask, 2'b11);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (k == 0) check("credit after first pop", o_ready, 1);
    end
    check("drain empty", o_valid, 0);

    // Reset with three beats in flight; the late CLUT answer must be ignored.
    @(negedge clk);
    i_ready = 1'b0; GPU_REG_TexFormat = 2'd1; i_laneMask = 2'b11;
    i_data = 32'hAB12_AB12; i_uLSB = 4'b0101; i_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    i_valid = 1'b0;
    #1 i_nrst = 1'b0;
    #1;
    check("midreset o_valid", o_valid, 0);
    check("midreset o_pixel", o_pixel, 0);
    check("midreset o_laneMask", o_laneMask, 0);
    check("midreset o_transparentBlack", o_transparentBlack, 0);
    #1 i_nrst = 1'b1;
    #1 check("midreset ready", o_ready, 1);
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check($sformatf("no stale beat %0d", c), o_valid, 0);
    end

    // Back-to-back beats with format changes; same raw word, different interpretation.
    expSeq[0] = 16'h7C00; expSeq[1] = 16'hAB12; expSeq[2] = 16'hFD02;
    fork
      begin
        @(negedge clk);
        i_laneMask = 2'b01; i_data = 32'h0000_AB12; i_valid = 1'b1;
        GPU_REG_TexFormat = 2'd1; i_uLSB = 4'b0001;
        @(negedge clk);
        GPU_REG_TexFormat = 2'd2;
        @(negedge clk);
        GPU_REG_TexFormat = 2'd0; i_uLSB = 4'b0000;
        @(negedge clk);
        i_valid = 1'b0; GPU_REG_TexFormat = 2'd1;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #2;
          if (o_valid) q.push_back(o_pixel[15:0]);
        end
      end
    join
    check("fmtchange beat count", q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < q.size()) check($sformatf("fmtchange beat %0d", k), q[k], expSeq[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
